// File: rtl/ppm16_if.sv
// Handshake/bus bundle between the TX FIFO side, the ppm16 modulator and the optical driver.
interface ppm16_if;
  logic        tx_start;
  logic [31:0] header;
  logic [15:0] data_len;
  logic [3:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        dout;
  logic        busy;
  logic        done;
  logic        underflow;

  modport master (
    output tx_start, header, data_len, din, din_valid,
    input  din_ready, dout, busy, done, underflow
  );

  modport slave (
    input  tx_start, header, data_len, din, din_valid,
    output din_ready, dout, busy, done, underflow
  );
endinterface

// File: rtl/ppm16_mod.sv
// ppm16_mod: 16-ary PPM transmitter. Frames preamble, SFD0, SFD1, 8 header symbols,
// 4 length symbols and data_len data symbols; each symbol is 16 chips of CHIP_BITS cycles.
//
// state    | meaning
// IDLE     | waiting for tx_start, dout low
// PREAMBLE | PREAMBLE_LEN copies of PREAMBLE_SYMBOL
// SFD0     | first start-of-frame delimiter symbol
// SFD1     | second start-of-frame delimiter symbol
// HEADER   | latched header, low nibble first
// LENGTH   | latched data_len, low nibble first
// DATA     | data symbols pulled from the FIFO
module ppm16_mod #(
  parameter int         CHIP_BITS       = 1,
  parameter int         PREAMBLE_LEN    = 4,
  parameter logic [3:0] PREAMBLE_SYMBOL = 4'hA,
  parameter logic [3:0] SFD0_SYMBOL     = 4'h5,
  parameter logic [3:0] SFD1_SYMBOL     = 4'hF
) (
  input  logic   clk,
  input  logic   resetn,
  ppm16_if.slave bus
);

  localparam int CB_W = (CHIP_BITS > 1) ? $clog2(CHIP_BITS) : 1;
  localparam logic [CB_W-1:0] CB_LAST = CB_W'(CHIP_BITS - 1);
  localparam logic [CB_W-1:0] CB_PRE  = CB_W'(CHIP_BITS - 2);
  localparam logic [15:0]     PRE_LAST = 16'(PREAMBLE_LEN - 1);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD0, SFD1, HEADER, LENGTH, DATA} state_t;

  state_t          state;
  logic [CB_W-1:0] chip_bit_count;
  logic [3:0]      chip_count;
  logic [15:0]     sym_count;
  logic [3:0]      sym;
  logic [31:0]     hdr_q;
  logic [15:0]     len_q;
  logic            dout_q, busy_q, done_q, uf_q;

  logic       at_boundary, pre_boundary, last_sym, fetch;
  logic [2:0] hdr_idx;
  logic [1:0] len_idx;
  logic [3:0] hdr_nib, len_nib, fetched_sym;

  // Slot 0 carries the pulse only for symbol 15 (pulse at slot 15 - symbol).
  function automatic logic first_chip(input logic [3:0] s);
    return s == 4'hF;
  endfunction

  // Symbol-boundary timing, FIFO fetch decision and next-nibble selection.
  always_comb begin
    at_boundary  = busy_q && (chip_count == 4'd15) && (chip_bit_count == CB_LAST);
    pre_boundary = (CHIP_BITS == 1) ? (chip_count == 4'd14)
                                    : ((chip_count == 4'd15) && (chip_bit_count == CB_PRE));
    last_sym     = ((state == LENGTH) && (sym_count == 16'd3) && (len_q == 16'd0)) ||
                   ((state == DATA) && (sym_count == len_q - 16'd1));
    fetch        = at_boundary &&
                   (((state == LENGTH) && (sym_count == 16'd3) && (len_q != 16'd0)) ||
                    ((state == DATA) && !last_sym));
    hdr_idx      = sym_count[2:0] + 3'd1;
    len_idx      = sym_count[1:0] + 2'd1;
    hdr_nib      = hdr_q[{hdr_idx, 2'b00} +: 4];
    len_nib      = len_q[{len_idx, 2'b00} +: 4];
    fetched_sym  = bus.din_valid ? bus.din : 4'h0;
  end

  assign bus.din_ready = fetch && bus.din_valid;
  assign bus.dout      = dout_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.underflow = uf_q;

  // Framing FSM with chip/symbol counters; dout is loaded with the chip that the counters point at.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      chip_bit_count <= '0;
      chip_count     <= '0;
      sym_count      <= '0;
      sym            <= '0;
      hdr_q          <= '0;
      len_q          <= '0;
      dout_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      uf_q           <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.tx_start) begin
          state          <= PREAMBLE;
          hdr_q          <= bus.header;
          len_q          <= bus.data_len;
          sym            <= PREAMBLE_SYMBOL;
          sym_count      <= '0;
          chip_bit_count <= '0;
          chip_count     <= '0;
          dout_q         <= first_chip(PREAMBLE_SYMBOL);
          busy_q         <= 1'b1;
          uf_q           <= 1'b0;
        end
      end else begin
        done_q <= pre_boundary && last_sym;
        if (chip_bit_count != CB_LAST) begin
          chip_bit_count <= chip_bit_count + 1'b1;
        end else begin
          chip_bit_count <= '0;
          if (chip_count != 4'd15) begin
            chip_count <= chip_count + 4'd1;
            dout_q     <= ((chip_count + 4'd1) == ~sym);
          end else begin
            chip_count <= '0;
            case (state)
              PREAMBLE: begin
                if (sym_count == PRE_LAST) begin
                  state     <= SFD0;
                  sym       <= SFD0_SYMBOL;
                  sym_count <= '0;
                  dout_q    <= first_chip(SFD0_SYMBOL);
                end else begin
                  sym_count <= sym_count + 16'd1;
                  dout_q    <= first_chip(PREAMBLE_SYMBOL);
                end
              end
              SFD0: begin
                state  <= SFD1;
                sym    <= SFD1_SYMBOL;
                dout_q <= first_chip(SFD1_SYMBOL);
              end
              SFD1: begin
                state     <= HEADER;
                sym       <= hdr_q[3:0];
                sym_count <= '0;
                dout_q    <= first_chip(hdr_q[3:0]);
              end
              HEADER: begin
                if (sym_count == 16'd7) begin
                  state     <= LENGTH;
                  sym       <= len_q[3:0];
                  sym_count <= '0;
                  dout_q    <= first_chip(len_q[3:0]);
                end else begin
                  sym_count <= sym_count + 16'd1;
                  sym       <= hdr_nib;
                  dout_q    <= first_chip(hdr_nib);
                end
              end
              LENGTH: begin
                if (sym_count != 16'd3) begin
                  sym_count <= sym_count + 16'd1;
                  sym       <= len_nib;
                  dout_q    <= first_chip(len_nib);
                end else if (len_q != 16'd0) begin
                  state     <= DATA;
                  sym_count <= '0;
                  sym       <= fetched_sym;
                  dout_q    <= first_chip(fetched_sym);
                  if (!bus.din_valid) uf_q <= 1'b1;
                end else begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  dout_q <= 1'b0;
                end
              end
              DATA: begin
                if (last_sym) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  dout_q <= 1'b0;
                end else begin
                  sym_count <= sym_count + 16'd1;
                  sym       <= fetched_sym;
                  dout_q    <= first_chip(fetched_sym);
                  if (!bus.din_valid) uf_q <= 1'b1;
                end
              end
              default: begin
                state  <= IDLE;
                busy_q <= 1'b0;
                dout_q <= 1'b0;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: doc/ppm16_mod.md
# ppm16_mod

Transmit-side 16-ary pulse-position modulator for the SPAD optical link. It frames a packet as preamble, SFD0, SFD1, an 8-symbol header, a 4-symbol length field, and then data symbols. Each 4-bit symbol is serialized as 16 chips of CHIP_BITS clock cycles each, with exactly one chip driven high. The block sits between the TX data FIFO and the laser/LED driver, and its output is decodable by the team's ppm16 demodulator using the `PREAMBLE_SYMBOL`, `` `SFD0 `` and `` `SFD1 `` values from `chips.vh`.

## Interface
- CHIP_BITS, 1, clock cycles per chip; dout is held for the whole chip.
- PREAMBLE_LEN, 4, number of `PREAMBLE_SYMBOL` symbols sent before SFD0 (1..15).
- clk  in  1  single clock for the block.
- resetn  in  1  reset, asynchronous, active-low.
- tx_start  in  1  single-cycle request to start a packet; honoured only in IDLE.
- header  in  32  primary header; sent as 8 symbols, header[3:0] first.
- data_len  in  16  number of data symbols; 0 means the packet has no data field.
- din  in  4  next data symbol, read from the FIFO.
- din_valid  in  1  din holds a valid symbol.
- din_ready  out  1  the block consumes din this cycle.
- dout  out  1  registered optical pulse output.
- busy  out  1  high from the cycle after an accepted tx_start through the last chip cycle.
- done  out  1  one-cycle pulse in the last cycle of the packet.
- underflow  out  1  sticky; set when a data symbol was needed and din_valid was low. Cleared by the next accepted tx_start.

## Operation
- States: IDLE, PREAMBLE, SFD0, SFD1, HEADER, LENGTH, DATA.
  - IDLE → PREAMBLE on tx_start.
  - PREAMBLE → SFD0 after PREAMBLE_LEN symbols.
  - SFD0 → SFD1 → HEADER, one symbol each.
  - HEADER → LENGTH after 8 symbols.
  - LENGTH → DATA after 4 symbols when data_len ≠ 0; otherwise LENGTH → IDLE.
  - DATA → IDLE after data_len symbols.
- On an accepted tx_start, header and data_len are latched into internal registers. Inputs may change afterwards without effect.
- Length field: 4 symbols carrying the latched data_len, least-significant nibble first.
- Counters:
  - chip_bit_count runs 0..CHIP_BITS-1.
  - chip_count runs 0..15.
  - sym_count is wide enough for 16-bit data_len and for PREAMBLE_LEN.
  - A symbol boundary occurs when chip_bit_count = CHIP_BITS-1 and chip_count = 15.
- Chip mapping: chip slot t (t = 0 first transmitted) is high iff t = 15 − symbol. After 16 chips the receiver's shift register therefore holds the pulse at index = symbol.
- Data fetch:
  - din_ready = din_valid during the boundary cycle that precedes each data symbol.
  - On the handshake, din is loaded into the symbol register.
  - If din_valid is low at that cycle, symbol 0 is sent, underflow is set, and the symbol still counts toward data_len. The packet is never stretched.
- tx_start while busy is ignored and does not queue.

## Timing
- Reset values: dout=0, busy=0, done=0, din_ready=0, underflow=0, state=IDLE, all counters 0.
- Asserting resetn low mid-packet forces dout=0 immediately (asynchronously). No partial symbol resumes after reset.
- tx_start sampled high in IDLE at cycle c → first chip of the first preamble symbol appears on dout at cycle c+1. busy rises at c+1.
- dout is registered and has no combinational path from inputs.
- Symbol period is 16·CHIP_BITS cycles.
- Packet length is (PREAMBLE_LEN+14+data_len)·16·CHIP_BITS cycles.
- done pulses in the final cycle of the packet; busy falls the cycle after.
- A new tx_start is accepted in the cycle after busy falls at the earliest. There is no guaranteed idle gap beyond that.
- data_len = 0xFFFF must not overflow sym_count.

## Test plan
- CHIP_BITS=1, PREAMBLE_LEN=4, header=0x76543210, data_len=2, din stream {0x3,0xC} always valid → 320-cycle packet.
  - Within each symbol, exactly one dout pulse at slot 15−s.
  - Symbol sequence: 4×`PREAMBLE_SYMBOL`, `` `SFD0 ``, `` `SFD1 ``, 0..7, 2,0,0,0, 3, C.
  - done at cycle 320; the ppm16 demodulator recovers 3 then C.
- CHIP_BITS=3, same packet → every pulse lasts 3 cycles; total length is 960 cycles.
- data_len=0 → packet ends after the length field (288 cycles at CHIP_BITS=1); din_ready never asserted.
- din_valid low at the boundary before the 2nd data symbol → symbol 0 sent and underflow=1. Packet length is unchanged and underflow clears on the next tx_start.
- tx_start pulsed mid-packet → ignored; sequence and timing are identical to the undisturbed run.
- resetn asserted during HEADER → dout, busy and din_ready drop to 0 asynchronously. A new tx_start after release produces a full, correct packet.
